alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : alu_arbiter (with helper alu_arbiter_alu)
// Description : Two-requester arbiter in front of an 8-bit signed ALU.
//               The arbiter grants one pending requester while IDLE, latches
//               its operands, computes the result in EXEC and holds it in
//               RESP until the consumer takes it.
//               Ports:
//                 clk, rst_n                  clock, async active-low reset
//                 reqN_valid/ready            requester N handshake
//                 reqN_sel, reqN_a, reqN_b    requester N operation/operands
//                 rsp_valid/ready             response handshake
//                 rsp_data, rsp_id            result and owning requester
//                 busy                        high whenever not IDLE
//                 done_cnt                    completed response handshakes
// Revision    : 1.0 - initial release
//==============================================================================

//------------------------------------------------------------------------------
// alu_arbiter_alu: combinational 8-bit signed ALU, two's-complement wrap.
//   11: (A <<< 3) + (B >>> 2)    10: B + 2*A
//   01: -B                       00: |3*B - A|  (difference wraps first)
// There is no carry output: every result wraps to 8 bits.
//------------------------------------------------------------------------------
module alu_arbiter_alu (
    input  logic        [1:0] i_sel,
    input  logic signed [7:0] i_a,
    input  logic signed [7:0] i_b,
    output logic signed [7:0] o_y
);

    logic signed [7:0] w_b_asr;
    logic signed [7:0] w_diff;
    logic signed [7:0] w_abs;

    assign w_b_asr = i_b >>> 2;
    assign w_diff  = (i_b + (i_b <<< 1)) - i_a;
    // Negating 0x80 yields 0x80 again, so |-128| stays -128 as intended.
    assign w_abs   = w_diff[7] ? -w_diff : w_diff;

    always_comb begin
        o_y = w_abs;
        case (i_sel)
            2'b11:   o_y = (i_a <<< 3) + w_b_asr;
            2'b10:   o_y = i_b + (i_a <<< 1);
            2'b01:   o_y = -i_b;
            default: o_y = w_abs;
        endcase
    end

endmodule

//------------------------------------------------------------------------------
// alu_arbiter: top level
//------------------------------------------------------------------------------
module alu_arbiter #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_sel,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_sel,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam bit               c_rr_en   = (RR_EN != 0);
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    // Requester that wins the next tie. Reset value 0 gives requester 0
    // priority; after every grant it points at the other requester.
    logic             r_prio;
    logic [1:0]       r_sel;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic             r_id;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_done_cnt;

    logic             w_idle;
    logic             w_any_valid;
    logic             w_gnt_id;
    logic             w_accept;
    logic [7:0]       w_alu_y;

    assign w_idle      = (r_state == S_IDLE);
    assign w_any_valid = req0_valid | req1_valid;
    // Tie: round-robin pointer or fixed requester 0; otherwise whoever is valid.
    assign w_gnt_id    = (req0_valid & req1_valid) ? (c_rr_en ? r_prio : 1'b0)
                                                   : req1_valid;
    assign w_accept    = w_idle & w_any_valid;

    assign req0_ready  = w_accept & ~w_gnt_id;
    assign req1_ready  = w_accept &  w_gnt_id;

    alu_arbiter_alu u_alu (
        .i_sel (r_sel),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_y   (w_alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_prio      <= 1'b0;
            r_sel       <= 2'b00;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_id        <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= w_gnt_id ? req1_sel : req0_sel;
                        r_a     <= w_gnt_id ? req1_a   : req0_a;
                        r_b     <= w_gnt_id ? req1_b   : req0_b;
                        r_id    <= w_gnt_id;
                        r_prio  <= ~w_gnt_id;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= w_alu_y;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done_cnt  <= r_done_cnt + c_cnt_one;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_id;
    assign busy      = r_busy;
    assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_arbiter
// Description : Directed bench for alu_arbiter. A round-robin instance with a
//               4-bit counter (cheap wrap) and a fixed-priority instance share
//               all inputs; both handshake in lockstep. Expected results are
//               queued at grant time and popped when the response appears.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [1:0] req0_sel, req1_sel;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;

    logic       rr_ready0, rr_ready1, rr_rsp_valid, rr_rsp_id, rr_busy;
    logic [7:0] rr_rsp_data;
    logic [3:0] rr_done_cnt;
    logic       fp_ready0, fp_ready1, fp_rsp_valid, fp_rsp_id, fp_busy;
    logic [7:0] fp_rsp_data;
    logic [15:0] fp_done_cnt;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_prio;
    logic [15:0] m_cnt;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1), .CNT_W(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rr_ready0), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rr_ready1), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rr_rsp_data),
        .rsp_id(rr_rsp_id), .busy(rr_busy), .done_cnt(rr_done_cnt)
    );

    alu_arbiter #(.RR_EN(0), .CNT_W(16)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_ready0), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_ready1), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data),
        .rsp_id(fp_rsp_id), .busy(fp_busy), .done_cnt(fp_done_cnt)
    );

    // Reference ALU written with integer arithmetic, truncated to 8 bits.
    function automatic logic [7:0] alu_model(input logic [1:0] s,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        int ia, ib, r, d;
        logic [7:0] d8;
        ia = int'($signed(a));
        ib = int'($signed(b));
        case (s)
            2'b11:   r = ia * 8 + (ib >>> 2);
            2'b10:   r = ib + 2 * ia;
            2'b01:   r = -ib;
            default: begin
                d  = 3 * ib - ia;
                d8 = d[7:0];
                r  = int'($signed(d8));
                if (r < 0) r = -r;
            end
        endcase
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUTs idle and valids already driven.
    task automatic issue(input bit keep);
        bit gid;
        logic [1:0] s;
        logic [7:0] a, b;
        exp_t e;
        #1;
        gid = (req0_valid && req1_valid) ? m_prio : req1_valid;
        chk("grant_rdy0", rr_ready0, !gid);
        chk("grant_rdy1", rr_ready1, gid);
        s = gid ? req1_sel : req0_sel;
        a = gid ? req1_a   : req0_a;
        b = gid ? req1_b   : req0_b;
        e.id   = gid;
        e.data = alu_model(s, a, b);
        exp_q.push_back(e);
        m_prio = ~gid;
        @(posedge clk);
        #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    // Follows one operation from just after its accept edge to the handshake.
    task automatic expect_rsp(input int stall, input bit fp_chk);
        exp_t e;
        logic [7:0] hold_data;
        logic       hold_id;
        @(negedge clk);
        chk("exec_valid", rr_rsp_valid, 1'b0);
        chk("exec_busy", rr_busy, 1'b1);
        chk("exec_rdy", {rr_ready0, rr_ready1}, 2'b00);
        // Operand changes while busy must not reach the result.
        req0_sel = 2'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_sel = 2'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
        @(negedge clk);
        chk("resp_valid", rr_rsp_valid, 1'b1);
        chk("resp_rdy", {rr_ready0, rr_ready1}, 2'b00);
        chk("q_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", rr_rsp_data, e.data);
            chk("rsp_id", rr_rsp_id, e.id);
        end
        if (fp_chk) chk("fp_rsp_id", fp_rsp_id, 1'b0);
        hold_data = rr_rsp_data;
        hold_id   = rr_rsp_id;
        if (stall > 0) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk("stall_valid", rr_rsp_valid, 1'b1);
                chk("stall_data", rr_rsp_data, hold_data);
                chk("stall_id", rr_rsp_id, hold_id);
                chk("stall_rdy", {rr_ready0, rr_ready1}, 2'b00);
                chk("stall_cnt", rr_done_cnt, m_cnt[3:0]);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        m_cnt = m_cnt + 16'd1;
        @(negedge clk);
        chk("hs_valid", rr_rsp_valid, 1'b0);
        chk("hs_busy", rr_busy, 1'b0);
        chk("hs_cnt", rr_done_cnt, m_cnt[3:0]);
        chk("fp_cnt", fp_done_cnt, m_cnt);
    endtask

    task automatic do_one(input bit id, input logic [1:0] s, input logic [7:0] a,
                          input logic [7:0] b, input int stall);
        if (id) begin
            req1_sel = s; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_sel = s; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        issue(1'b0);
        expect_rsp(stall, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prio = 1'b0;
        m_cnt  = 16'd0;
    endtask

    initial begin
        req0_valid = 0; req1_valid = 0; rsp_ready = 1'b1;
        req0_sel = 0; req0_a = 0; req0_b = 0;
        req1_sel = 0; req1_a = 0; req1_b = 0;
        model_reset();

        // Reset state, readies still follow the valids while held in reset.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", rr_rsp_valid, 1'b0);
        chk("rst_data", rr_rsp_data, 8'h00);
        chk("rst_id", rr_rsp_id, 1'b0);
        chk("rst_busy", rr_busy, 1'b0);
        chk("rst_cnt", rr_done_cnt, 4'h0);
        chk("rst_rdy_none", {rr_ready0, rr_ready1}, 2'b00);
        req1_valid = 1'b1;
        #1;
        chk("rst_rdy_r1", {rr_ready0, rr_ready1}, 2'b01);
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ALU operations, including the wrap and |-128| cases.
        do_one(1'b0, 2'b11, 8'd1, 8'd8, 0);
        do_one(1'b1, 2'b10, 8'd3, 8'd4, 0);
        do_one(1'b1, 2'b01, 8'd0, 8'h80, 0);
        do_one(1'b1, 2'b00, 8'd10, 8'd2, 0);
        do_one(1'b1, 2'b00, 8'h80, 8'd0, 0);
        do_one(1'b0, 2'b11, 8'hFF, 8'hFB, 0);

        // Reset in the middle of EXEC drops the operation.
        do_one(1'b0, 2'b10, 8'd7, 8'd9, 0);
        req1_sel = 2'b10; req1_a = 8'd20; req1_b = 8'd1; req1_valid = 1'b1;
        issue(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rr_rsp_valid, 1'b0);
        chk("mid_rst_data", rr_rsp_data, 8'h00);
        chk("mid_rst_id", rr_rsp_id, 1'b0);
        chk("mid_rst_busy", rr_busy, 1'b0);
        chk("mid_rst_cnt", rr_done_cnt, 4'h0);
        chk("mid_rst_fpcnt", fp_done_cnt, 16'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_novalid", rr_rsp_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_novalid", rr_rsp_valid, 1'b0);

        // A valid withdrawn before the edge leaves no trace.
        req1_valid = 1'b1;
        #2 req1_valid = 1'b0;
        @(negedge clk);
        chk("drop_busy", rr_busy, 1'b0);
        chk("drop_valid", rr_rsp_valid, 1'b0);

        // Both requesters valid throughout: RR alternates from 0, FP stays on 0.
        req0_sel = 2'b10; req0_a = 8'd5; req0_b = 8'd1;
        req1_sel = 2'b01; req1_a = 8'd0; req1_b = 8'd7;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1);
            expect_rsp(0, 1'b1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_cnt4", rr_done_cnt, 4'd4);

        // Consumer stalls five cycles.
        do_one(1'b1, 2'b11, 8'd2, 8'hF0, 5);

        // Random traffic up to the counter's all-ones value, then wrap.
        for (int i = 0; i < 10; i++) begin
            int p;
            p = int'($urandom_range(1, 3));
            req0_sel = 2'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_sel = 2'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
            req0_valid = p[0];
            req1_valid = p[1];
            issue(1'b0);
            expect_rsp(0, 1'b0);
        end
        chk("cnt_allones", rr_done_cnt, 4'hF);
        do_one(1'b0, 2'b00, 8'd1, 8'd1, 0);
        chk("cnt_wrap", rr_done_cnt, 4'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
